// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM encoding,
// BCD digit geometry and requester index width.
package bcd_conv_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;
    localparam int REQ_ID_W  = 3;
    // Wide enough for CONV_LAT up to 7
    localparam int CNT_W     = 3;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, wrapping modulo N. Returns a one-hot grant and its index.
module bcd_conv_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_idx;

    // Rotate the valid vector so bit k is the requester k places past the pointer
    always_comb begin
        w_rot = '0;
        for (int p = 0; p < N; p++) begin
            if (i_ptr == IDX_W'(p)) begin
                for (int k = 0; k < N; k++) begin
                    w_rot[k] = i_valid[(p + k) % N];
                end
            end
        end
    end

    // Lowest rotated offset wins; map it back to an absolute requester index
    always_comb begin
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                if (int'(i_ptr) + k >= N) begin
                    w_idx = IDX_W'(int'(i_ptr) + k - N);
                end else begin
                    w_idx = IDX_W'(int'(i_ptr) + k);
                end
            end
        end
    end

    assign o_any       = |i_valid;
    assign o_grant_idx = w_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign o_grant[gi] = o_any && (w_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Sequences one shared external binary-to-BCD converter among NUM_REQ
// clients: round-robin accept, hold the operand for CONV_LAT cycles,
// sample the result, then pulse a one-cycle response to the owner.
module bcd_conv_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BIN_W    = 8,
    parameter int BCD_W    = 12,
    parameter int CONV_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*BIN_W-1:0] req_bin,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic [2:0]               rsp_id,
    output logic                     rsp_err,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic [BCD_W-1:0]         conv_bcd,
    output logic                     busy
);

    import bcd_conv_arbiter_pkg::*;

    localparam int NUM_DIGITS = BCD_W / DIGIT_W;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || CONV_LAT < 1 || CONV_LAT > 7 ||
            BCD_W != NUM_DIGITS * DIGIT_W) begin : g_cfg_check
            $error("bcd_conv_arbiter: NUM_REQ must be 2..8, CONV_LAT 1..7, BCD_W a multiple of 4");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [REQ_ID_W-1:0]   r_ptr;
    logic [REQ_ID_W-1:0]   r_owner;
    logic [REQ_ID_W-1:0]   r_rsp_id;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIN_W-1:0]      r_conv_bin;
    logic [BCD_W-1:0]      r_rsp_bcd;
    logic                  r_rsp_err;

    logic [NUM_REQ-1:0]    w_grant;
    logic [REQ_ID_W-1:0]   w_grant_idx;
    logic                  w_any;
    logic [REQ_ID_W-1:0]   w_ptr_next;
    logic [BIN_W-1:0]      w_sel_bin;
    logic                  w_conv_last;
    logic [NUM_DIGITS-1:0] w_digit_bad;
    logic                  w_bcd_err;

    bcd_conv_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (REQ_ID_W)
    ) u_rr_pick (
        .i_valid     (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Operand of the granted requester (grant is one-hot, so OR-merge)
    always_comb begin
        w_sel_bin = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_bin = w_sel_bin | req_bin[i*BIN_W +: BIN_W];
            end
        end
    end

    // Any nibble above 9 marks the converter sample as invalid BCD
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_chk
            assign w_digit_bad[gi] = conv_bcd[gi*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX);
        end
    endgenerate

    assign w_bcd_err   = |w_digit_bad;
    assign w_conv_last = (r_cnt == CNT_W'(CONV_LAT - 1));
    assign w_ptr_next  = (w_grant_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_next = ST_CONV;
            ST_CONV: if (w_conv_last) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: accept pulse in IDLE, response pulse to the owner in RESP
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (r_state != ST_IDLE);
        if (r_state == ST_IDLE && !rst) begin
            req_ready = w_grant;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_state == ST_RESP) && (r_rsp_id == REQ_ID_W'(i));
        end
    end

    // Datapath: latch operand/owner on accept, count latency, capture result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_rsp_id   <= '0;
            r_cnt      <= '0;
            r_conv_bin <= '0;
            r_rsp_bcd  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_conv_bin <= w_sel_bin;
                        r_owner    <= w_grant_idx;
                        r_ptr      <= w_ptr_next;
                        r_cnt      <= '0;
                    end
                end
                ST_CONV: begin
                    if (w_conv_last) begin
                        r_rsp_bcd <= conv_bcd;
                        r_rsp_err <= w_bcd_err;
                        r_rsp_id  <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv_bin = r_conv_bin;
    assign rsp_bcd  = r_rsp_bcd;
    assign rsp_id   = r_rsp_id;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench: two instances (CONV_LAT=1 and CONV_LAT=3) each with
// a behavioural binary-to-BCD converter; directed scenarios plus a
// randomized run checked against a cycle-level round-robin model.
module tb_bcd_conv_arbiter;

    logic clk;
    int   n_pass  = 0;
    int   n_total = 0;

    // Instance with CONV_LAT = 1
    logic        rst1;
    logic [3:0]  rv1, rdy1, rspv1;
    logic [31:0] rb1;
    logic [11:0] bcd1, cbcd1, fval1;
    logic [2:0]  id1;
    logic        err1, busy1, force1;
    logic [7:0]  cb1;

    // Instance with CONV_LAT = 3
    logic        rst3;
    logic [3:0]  rv3, rdy3, rspv3;
    logic [31:0] rb3;
    logic [11:0] bcd3, cbcd3;
    logic [2:0]  id3;
    logic        err3, busy3;
    logic [7:0]  cb3;

    function automatic logic [11:0] bin2bcd(input logic [7:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    assign cbcd1 = force1 ? fval1 : bin2bcd(cb1);
    assign cbcd3 = bin2bcd(cb3);

    bcd_conv_arbiter #(.NUM_REQ(4), .BIN_W(8), .BCD_W(12), .CONV_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(rv1), .req_bin(rb1), .req_ready(rdy1),
        .rsp_valid(rspv1), .rsp_bcd(bcd1), .rsp_id(id1), .rsp_err(err1),
        .conv_bin(cb1), .conv_bcd(cbcd1), .busy(busy1)
    );

    bcd_conv_arbiter #(.NUM_REQ(4), .BIN_W(8), .BCD_W(12), .CONV_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_bin(rb3), .req_ready(rdy3),
        .rsp_valid(rspv3), .rsp_bcd(bcd3), .rsp_id(id3), .rsp_err(err3),
        .conv_bin(cb3), .conv_bcd(cbcd3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset1();
        adv();
        rst1 = 1'b1;
        rv1  = '0;
        adv();
        rst1 = 1'b0;
    endtask

    task automatic do_reset3();
        adv();
        rst3 = 1'b1;
        rv3  = '0;
        adv();
        rst3 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1; rv1 = '0; rv3 = '0; rb1 = '0; rb3 = '0;
        force1 = 1'b0; fval1 = '0;
        adv(); adv(); #1;
        n_total++; if (rdy1 !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", rdy1); else n_pass++;
        n_total++; if (rspv1 !== 4'b0000) $display("FAIL reset_rsp_valid got=%b exp=0000", rspv1); else n_pass++;
        n_total++; if (bcd1 !== 12'h000) $display("FAIL reset_rsp_bcd got=%h exp=000", bcd1); else n_pass++;
        n_total++; if (id1 !== 3'd0) $display("FAIL reset_rsp_id got=%0d exp=0", id1); else n_pass++;
        n_total++; if (err1 !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", err1); else n_pass++;
        n_total++; if (cb1 !== 8'd0) $display("FAIL reset_conv_bin got=%0d exp=0", cb1); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy1); else n_pass++;
        n_total++; if (busy3 !== 1'b0 || cb3 !== 8'd0) $display("FAIL reset_lat3 got busy=%b conv_bin=%0d exp busy=0 conv_bin=0", busy3, cb3); else n_pass++;
        adv();
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_single();
        do_reset1();
        rb1[7:0] = 8'd255;
        rv1 = 4'b0001;
        #1;
        n_total++; if (rdy1 !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", rdy1); else n_pass++;
        adv(); rv1 = '0; #1;
        n_total++; if (busy1 !== 1'b1 || cb1 !== 8'd255) $display("FAIL single_conv got busy=%b conv_bin=%0d exp busy=1 conv_bin=255", busy1, cb1); else n_pass++;
        n_total++; if (rspv1 !== 4'b0000) $display("FAIL single_early_rsp got=%b exp=0000", rspv1); else n_pass++;
        adv(); #1;
        n_total++; if (rspv1 !== 4'b0001) $display("FAIL single_rsp_valid got=%b exp=0001", rspv1); else n_pass++;
        n_total++; if (bcd1 !== 12'h255 || id1 !== 3'd0 || err1 !== 1'b0) $display("FAIL single_rsp got bcd=%h id=%0d err=%b exp bcd=255 id=0 err=0", bcd1, id1, err1); else n_pass++;
        $display("single: rsp id=%0d bcd=%h", id1, bcd1);
        adv(); #1;
        n_total++; if (rspv1 !== 4'b0000 || busy1 !== 1'b0 || bcd1 !== 12'h255) $display("FAIL single_after got rsp_valid=%b busy=%b bcd=%h exp 0000/0/255", rspv1, busy1, bcd1); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [11:0] exp_bcd [4];
        logic [3:0]  acc;
        int k, r, last;
        exp_bcd = '{12'h000, 12'h009, 12'h059, 12'h100};
        do_reset1();
        rb1 = {8'd100, 8'd59, 8'd9, 8'd0};
        rv1 = 4'b1111;
        k = 0; r = 0; last = 0; acc = '0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                adv();
                rv1 = rv1 & ~acc;
            end
            #1;
            acc = rdy1;
            if (rdy1 !== 4'b0000) begin
                n_total++; if (k > 3 || rdy1 !== 4'(1 << k)) $display("FAIL simul_grant_order got=%b exp=%b", rdy1, 4'(1 << k)); else n_pass++;
                if (k > 0) begin
                    n_total++; if (c - last != 3) $display("FAIL simul_accept_spacing got=%0d exp=3", c - last); else n_pass++;
                end
                last = c;
                k++;
            end
            if (rspv1 !== 4'b0000 && r < 4) begin
                n_total++; if (rspv1 !== 4'(1 << r) || bcd1 !== exp_bcd[r] || id1 !== 3'(r)) $display("FAIL simul_rsp got valid=%b bcd=%h id=%0d exp valid=%b bcd=%h id=%0d", rspv1, bcd1, id1, 4'(1 << r), exp_bcd[r], r); else n_pass++;
                $display("simultaneous: rsp id=%0d bcd=%h", id1, bcd1);
                r++;
            end
        end
        n_total++; if (k != 4 || r != 4) $display("FAIL simul_count got accepts=%0d rsps=%0d exp 4/4", k, r); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [11:0] q_bcd[$];
        int          q_id[$];
        logic [3:0]  acc, exp_g;
        int grants, rsps;
        do_reset1();
        rb1 = 32'($urandom);
        rv1 = 4'b1010;
        grants = 0; rsps = 0; acc = '0;
        for (int c = 0; c < 28; c++) begin
            if (c > 0) begin
                adv();
                for (int i = 0; i < 4; i++) if (acc[i]) rb1[i*8 +: 8] = 8'($urandom);
                if (grants >= 8) rv1 = '0;
            end
            #1;
            acc = rdy1;
            if (rdy1 !== 4'b0000) begin
                exp_g = (grants % 2 == 0) ? 4'b0010 : 4'b1000;
                n_total++; if (rdy1 !== exp_g) $display("FAIL fair_grant got=%b exp=%b", rdy1, exp_g); else n_pass++;
                q_id.push_back((grants % 2 == 0) ? 1 : 3);
                q_bcd.push_back(bin2bcd(rb1[((grants % 2 == 0) ? 1 : 3)*8 +: 8]));
                grants++;
            end
            if (rspv1 !== 4'b0000) begin
                if (q_id.size() == 0) begin
                    n_total++; $display("FAIL fair_spurious_rsp got=%b exp=0000", rspv1);
                end else begin
                    n_total++; if (rspv1 !== 4'(1 << q_id[0]) || bcd1 !== q_bcd[0]) $display("FAIL fair_rsp got valid=%b bcd=%h exp valid=%b bcd=%h", rspv1, bcd1, 4'(1 << q_id[0]), q_bcd[0]); else n_pass++;
                    $display("fairness: rsp id=%0d bcd=%h", id1, bcd1);
                    void'(q_id.pop_front());
                    void'(q_bcd.pop_front());
                    rsps++;
                end
            end
        end
        n_total++; if (grants != 8 || rsps != 8) $display("FAIL fair_count got grants=%0d rsps=%0d exp 8/8", grants, rsps); else n_pass++;
    endtask

    task automatic test_error_flag();
        do_reset1();
        force1 = 1'b1;
        fval1  = 12'h0A3;
        rb1[31:24] = 8'($urandom);
        rv1 = 4'b1000;
        #1;
        n_total++; if (rdy1 !== 4'b1000) $display("FAIL err_ready got=%b exp=1000", rdy1); else n_pass++;
        adv(); rv1 = '0;
        adv(); #1;
        n_total++; if (rspv1 !== 4'b1000 || err1 !== 1'b1) $display("FAIL err_flag got valid=%b err=%b exp valid=1000 err=1", rspv1, err1); else n_pass++;
        n_total++; if (bcd1 !== 12'h0A3 || id1 !== 3'd3) $display("FAIL err_raw_bcd got bcd=%h id=%0d exp bcd=0a3 id=3", bcd1, id1); else n_pass++;
        $display("error: rsp id=%0d bcd=%h err=%b", id1, bcd1, err1);
        adv();
        force1 = 1'b0;
    endtask

    task automatic test_random();
        int          q_id[$], q_due[$];
        logic [11:0] q_bcd[$];
        logic [3:0]  acc, exp_rdy;
        int ptr, next_ok, g;
        bit found;
        do_reset1();
        ptr = 0; next_ok = 0; acc = '0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) adv();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) rv1[i] = 1'b0;
                else if (!rv1[i]) begin
                    if ($urandom_range(2) == 0) begin
                        rb1[i*8 +: 8] = 8'($urandom);
                        rv1[i] = 1'b1;
                    end
                end else if ($urandom_range(19) == 0) rv1[i] = 1'b0;
            end
            #1;
            exp_rdy = '0;
            if (c >= next_ok && rv1 != 4'b0000) begin
                found = 1'b0; g = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && rv1[(ptr + k) % 4]) begin
                        found = 1'b1;
                        g = (ptr + k) % 4;
                    end
                end
                exp_rdy = 4'(1 << g);
                q_id.push_back(g);
                q_bcd.push_back(bin2bcd(rb1[g*8 +: 8]));
                q_due.push_back(c + 2);
                ptr = (g + 1) % 4;
                next_ok = c + 3;
            end
            n_total++; if (rdy1 !== exp_rdy) $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, rdy1, exp_rdy); else n_pass++;
            acc = rdy1;
            if (q_due.size() > 0 && q_due[0] == c) begin
                n_total++; if (rspv1 !== 4'(1 << q_id[0]) || bcd1 !== q_bcd[0] || id1 !== 3'(q_id[0]) || err1 !== 1'b0)
                    $display("FAIL rand_rsp cycle=%0d got valid=%b bcd=%h id=%0d err=%b exp valid=%b bcd=%h id=%0d err=0", c, rspv1, bcd1, id1, err1, 4'(1 << q_id[0]), q_bcd[0], q_id[0]);
                else n_pass++;
                $display("random: rsp id=%0d bcd=%h", id1, bcd1);
                void'(q_id.pop_front());
                void'(q_bcd.pop_front());
                void'(q_due.pop_front());
            end else begin
                n_total++; if (rspv1 !== 4'b0000) $display("FAIL rand_no_rsp cycle=%0d got=%b exp=0000", c, rspv1); else n_pass++;
            end
        end
        adv();
        rv1 = '0;
    endtask

    task automatic test_latency();
        logic [7:0] op0;
        do_reset3();
        op0 = 8'($urandom);
        rb3[23:16] = 8'd42;
        rv3 = 4'b0100;
        #1;
        n_total++; if (rdy3 !== 4'b0100) $display("FAIL lat_ready got=%b exp=0100", rdy3); else n_pass++;
        adv();
        rv3 = 4'b0001;
        rb3[7:0] = op0;
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) adv();
            #1;
            n_total++; if (cb3 !== 8'd42 || rdy3 !== 4'b0000 || rspv3 !== 4'b0000)
                $display("FAIL lat_conv_hold t=%0d got conv_bin=%0d ready=%b rsp=%b exp 42/0000/0000", t, cb3, rdy3, rspv3);
            else n_pass++;
        end
        adv(); #1;
        n_total++; if (rspv3 !== 4'b0100 || bcd3 !== 12'h042 || id3 !== 3'd2) $display("FAIL lat_rsp got valid=%b bcd=%h id=%0d exp 0100/042/2", rspv3, bcd3, id3); else n_pass++;
        n_total++; if (rdy3 !== 4'b0000) $display("FAIL lat_no_early_accept got=%b exp=0000", rdy3); else n_pass++;
        $display("latency: rsp id=%0d bcd=%h", id3, bcd3);
        adv(); #1;
        n_total++; if (rdy3 !== 4'b0001 || rspv3 !== 4'b0000) $display("FAIL lat_next_accept got ready=%b rsp=%b exp 0001/0000", rdy3, rspv3); else n_pass++;
        adv(); rv3 = '0;
        adv(); adv(); adv(); #1;
        n_total++; if (rspv3 !== 4'b0001 || bcd3 !== bin2bcd(op0)) $display("FAIL lat_second_rsp got valid=%b bcd=%h exp 0001/%h", rspv3, bcd3, bin2bcd(op0)); else n_pass++;
        $display("latency: rsp id=%0d bcd=%h", id3, bcd3);
        adv();
    endtask

    task automatic test_mid_reset();
        do_reset3();
        rb3 = 32'($urandom);
        rv3 = 4'b0010;
        #1;
        n_total++; if (rdy3 !== 4'b0010) $display("FAIL mrst_ready got=%b exp=0010", rdy3); else n_pass++;
        adv(); rv3 = '0;
        adv(); rst3 = 1'b1; #1;
        n_total++; if (busy3 !== 1'b1) $display("FAIL mrst_busy_before got=%b exp=1", busy3); else n_pass++;
        adv(); rst3 = 1'b0; rv3 = 4'b1111; #1;
        n_total++; if (busy3 !== 1'b0 || rspv3 !== 4'b0000 || bcd3 !== 12'h000 || id3 !== 3'd0 || err3 !== 1'b0 || cb3 !== 8'd0)
            $display("FAIL mrst_outputs got busy=%b rsp=%b bcd=%h id=%0d err=%b conv_bin=%0d exp all zero", busy3, rspv3, bcd3, id3, err3, cb3);
        else n_pass++;
        n_total++; if (rdy3 !== 4'b0001) $display("FAIL mrst_ptr_restart got=%b exp=0001", rdy3); else n_pass++;
        adv(); rv3 = '0; #1;
        n_total++; if (rspv3 !== 4'b0000) $display("FAIL mrst_stale_rsp got=%b exp=0000", rspv3); else n_pass++;
        adv(); adv(); adv(); #1;
        n_total++; if (rspv3 !== 4'b0001 || bcd3 !== bin2bcd(rb3[7:0])) $display("FAIL mrst_new_rsp got valid=%b bcd=%h exp 0001/%h", rspv3, bcd3, bin2bcd(rb3[7:0])); else n_pass++;
        $display("mid_reset: rsp id=%0d bcd=%h", id3, bcd3);
        adv();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_error_flag();
        test_random();
        test_latency();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
